hazard_controller: RTL and testbench

- Pipeline hazard sequencer for the 5-stage MIPS core. It works alongside the EX-stage forwarding logic.
- Detects load-use hazards, which forwarding cannot cover, and branch-taken flushes. It also sequences a multi-cycle MULT/DIV unit and stalls HI/LO consumers while that unit is busy.
- Drives the PC and IF/ID write enables, the IF/ID flush, the ID/EX bubble insert and the MULT/DIV start strobe.
- Keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/hazard_controller_if.sv | 34 +++
 rtl/hazard_controller_md_sequencer.sv | 60 ++++++
 rtl/hazard_controller.sv | 55 +++++
 tb/tb_hazard_controller.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core hazard logic: MULT/DIV op encodings,
// hazard sequencer state type and default latencies.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10
  } md_op_e;

  typedef enum logic {
    HC_IDLE    = 1'b0,
    HC_MD_BUSY = 1'b1
  } hc_state_e;

  localparam int DEF_MUL_CYCLES = 4;
  localparam int DEF_DIV_CYCLES = 32;
  localparam int DEF_CNT_W      = 32;

  // Encoding 2'b11 is reserved and behaves exactly like MD_NONE.
  function automatic logic is_md_op(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// ID/EX hazard-detection inputs and pipeline control outputs between the
// pipeline datapath (master) and the hazard controller (slave).
interface hazard_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [1:0] id_md_op;
  logic       id_reads_hilo;
  logic       id_ex_mem_read;
  logic [4:0] id_ex_write_reg_addr;
  logic       ex_branch_taken;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       md_start;
  logic       md_is_div;
  logic       md_busy;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_op, id_reads_hilo,
           id_ex_mem_read, id_ex_write_reg_addr, ex_branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
           md_start, md_is_div, md_busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_op, id_reads_hilo,
           id_ex_mem_read, id_ex_write_reg_addr, ex_branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
           md_start, md_is_div, md_busy
  );
endinterface

// File: rtl/hazard_controller_md_sequencer.sv
// MULT/DIV issue sequencer: launches the unit from IDLE and holds busy for the
// configured number of cycles.
module md_sequencer
  import mips_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] md_op,
  input  logic       block,
  output logic       md_start,
  output logic       md_is_div,
  output logic       busy
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);

  hc_state_e     state, state_next;
  logic [CW-1:0] md_cnt, md_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= HC_IDLE;
      md_cnt <= '0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
    end
  end

  // block covers a taken branch (op is squashed) and a load-use stall (op not yet issuable).
  always_comb begin
    state_next  = state;
    md_cnt_next = md_cnt;
    md_start    = 1'b0;
    md_is_div   = 1'b0;
    busy        = 1'b0;
    case (state)
      HC_IDLE: begin
        if (is_md_op(md_op) && !block) begin
          md_start    = 1'b1;
          md_is_div   = md_op[1];
          state_next  = HC_MD_BUSY;
          md_cnt_next = md_op[1] ? DIV_LAST : MUL_LAST;
        end
      end
      HC_MD_BUSY: begin
        busy = 1'b1;
        if (md_cnt == '0) state_next = HC_IDLE;
        else              md_cnt_next = md_cnt - CW'(1);
      end
      default: state_next = HC_IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use and MULT/DIV stalls, branch flushes,
// and a saturating stall-cycle counter.
module hazard_controller
  import mips_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  hazard_if.slave          hz,
  output logic [CNT_W-1:0] stall_cycles
);

  logic load_use;
  logic md_hazard;
  logic stall;
  logic busy;

  md_sequencer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_md_seq (
    .clk      (clk),
    .rst      (rst),
    .md_op    (hz.id_md_op),
    .block    (hz.ex_branch_taken || load_use),
    .md_start (hz.md_start),
    .md_is_div(hz.md_is_div),
    .busy     (busy)
  );

  // A taken branch squashes the stalled instruction, so the flush wins and the PC moves on.
  always_comb begin
    load_use = hz.id_ex_mem_read && (hz.id_ex_write_reg_addr != 5'd0) &&
               ((hz.id_uses_rs && (hz.id_rs == hz.id_ex_write_reg_addr)) ||
                (hz.id_uses_rt && (hz.id_rt == hz.id_ex_write_reg_addr)));
    md_hazard       = busy && (is_md_op(hz.id_md_op) || hz.id_reads_hilo);
    stall           = (load_use || md_hazard) && !hz.ex_branch_taken;
    hz.pc_write     = !stall;
    hz.if_id_write  = !stall;
    hz.if_id_flush  = hz.ex_branch_taken;
    hz.id_ex_bubble = stall || hz.ex_branch_taken;
    hz.md_busy      = busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller: default instance plus a
// narrow-counter instance for saturation.
module tb_hazard_controller;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] stall_cycles;
  logic [1:0]  stall_cycles_s;
  int          total = 0;
  int          bad = 0;

  hazard_if hz ();
  hazard_if hz_s ();

  hazard_controller dut (
    .clk(clk), .rst(rst), .hz(hz), .stall_cycles(stall_cycles)
  );

  hazard_controller #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .hz(hz_s), .stall_cycles(stall_cycles_s)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0;
    hz.id_md_op = MD_NONE; hz.id_reads_hilo = 1'b0; hz.id_ex_mem_read = 1'b0;
    hz.id_ex_write_reg_addr = 5'd0; hz.ex_branch_taken = 1'b0;
    hz_s.id_rs = 5'd0; hz_s.id_rt = 5'd0; hz_s.id_uses_rs = 1'b0; hz_s.id_uses_rt = 1'b0;
    hz_s.id_md_op = MD_NONE; hz_s.id_reads_hilo = 1'b0; hz_s.id_ex_mem_read = 1'b0;
    hz_s.id_ex_write_reg_addr = 5'd0; hz_s.ex_branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #1;
    total++; if (hz.pc_write !== 1'b1) begin bad++; $display("[TB] FAIL reset_pc_write got=%b exp=1", hz.pc_write); end
    total++; if (hz.if_id_write !== 1'b1) begin bad++; $display("[TB] FAIL reset_if_id_write got=%b exp=1", hz.if_id_write); end
    total++; if (hz.id_ex_bubble !== 1'b0) begin bad++; $display("[TB] FAIL reset_bubble got=%b exp=0", hz.id_ex_bubble); end
    total++; if (hz.md_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_md_busy got=%b exp=0", hz.md_busy); end
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("[TB] FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    hz.id_ex_mem_read = 1'b1; hz.id_ex_write_reg_addr = 5'd8; hz.id_rs = 5'd8; hz.id_uses_rs = 1'b1;
    #1;
    total++; if (hz.pc_write !== 1'b0) begin bad++; $display("[TB] FAIL lu_pc_write got=%b exp=0", hz.pc_write); end
    total++; if (hz.if_id_write !== 1'b0) begin bad++; $display("[TB] FAIL lu_if_id_write got=%b exp=0", hz.if_id_write); end
    total++; if (hz.id_ex_bubble !== 1'b1) begin bad++; $display("[TB] FAIL lu_bubble got=%b exp=1", hz.id_ex_bubble); end
    total++; if (hz.if_id_flush !== 1'b0) begin bad++; $display("[TB] FAIL lu_flush got=%b exp=0", hz.if_id_flush); end
    @(negedge clk);
    hz.id_ex_write_reg_addr = 5'd0; hz.id_rs = 5'd0;
    #1;
    total++; if (stall_cycles !== 32'd1) begin bad++; $display("[TB] FAIL lu_count got=%0d exp=1", stall_cycles); end
    total++; if (hz.pc_write !== 1'b1) begin bad++; $display("[TB] FAIL lu_dest0_pc_write got=%b exp=1", hz.pc_write); end
    @(negedge clk);
    hz.id_ex_write_reg_addr = 5'd8; hz.id_rs = 5'd8; hz.id_uses_rs = 1'b0;
    #1;
    total++; if (hz.pc_write !== 1'b1) begin bad++; $display("[TB] FAIL lu_nouse_pc_write got=%b exp=1", hz.pc_write); end
    total++; if (hz.id_ex_bubble !== 1'b0) begin bad++; $display("[TB] FAIL lu_nouse_bubble got=%b exp=0", hz.id_ex_bubble); end
    @(negedge clk);
    hz.id_rs = 5'd3; hz.id_rt = 5'd8; hz.id_uses_rt = 1'b1;
    #1;
    total++; if (hz.pc_write !== 1'b0) begin bad++; $display("[TB] FAIL lu_rt_pc_write got=%b exp=0", hz.pc_write); end
    @(negedge clk);
    clear_inputs();
    #1;
    total++; if (stall_cycles !== 32'd2) begin bad++; $display("[TB] FAIL lu_rt_count got=%0d exp=2", stall_cycles); end
  endtask

  task automatic test_branch_hazard();
    do_reset();
    hz.id_ex_mem_read = 1'b1; hz.id_ex_write_reg_addr = 5'd8; hz.id_rs = 5'd8; hz.id_uses_rs = 1'b1;
    hz.ex_branch_taken = 1'b1;
    #1;
    total++; if (hz.pc_write !== 1'b1) begin bad++; $display("[TB] FAIL br_pc_write got=%b exp=1", hz.pc_write); end
    total++; if (hz.if_id_flush !== 1'b1) begin bad++; $display("[TB] FAIL br_flush got=%b exp=1", hz.if_id_flush); end
    total++; if (hz.id_ex_bubble !== 1'b1) begin bad++; $display("[TB] FAIL br_bubble got=%b exp=1", hz.id_ex_bubble); end
    @(negedge clk);
    clear_inputs();
    hz.id_md_op = MD_MULT; hz.ex_branch_taken = 1'b1;
    #1;
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("[TB] FAIL br_count got=%0d exp=0", stall_cycles); end
    total++; if (hz.md_start !== 1'b0) begin bad++; $display("[TB] FAIL br_md_start got=%b exp=0", hz.md_start); end
    @(negedge clk);
    hz.id_md_op = 2'b11; hz.ex_branch_taken = 1'b0;
    #1;
    total++; if (hz.md_busy !== 1'b0) begin bad++; $display("[TB] FAIL br_md_busy got=%b exp=0", hz.md_busy); end
    total++; if (hz.md_start !== 1'b0) begin bad++; $display("[TB] FAIL reserved_md_start got=%b exp=0", hz.md_start); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_mult_mfhi();
    do_reset();
    hz.id_md_op = MD_MULT;
    #1;
    total++; if (hz.md_start !== 1'b1) begin bad++; $display("[TB] FAIL mul_start got=%b exp=1", hz.md_start); end
    total++; if (hz.md_is_div !== 1'b0) begin bad++; $display("[TB] FAIL mul_is_div got=%b exp=0", hz.md_is_div); end
    total++; if (hz.pc_write !== 1'b1) begin bad++; $display("[TB] FAIL mul_issue_pc_write got=%b exp=1", hz.pc_write); end
    @(negedge clk);
    hz.id_md_op = MD_NONE; hz.id_reads_hilo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (hz.md_busy !== 1'b1) begin bad++; $display("[TB] FAIL mul_busy[%0d] got=%b exp=1", i, hz.md_busy); end
      total++; if (hz.pc_write !== 1'b0) begin bad++; $display("[TB] FAIL mfhi_stall[%0d] got=%b exp=0", i, hz.pc_write); end
      @(negedge clk);
    end
    #1;
    total++; if (hz.md_busy !== 1'b0) begin bad++; $display("[TB] FAIL mul_done_busy got=%b exp=0", hz.md_busy); end
    total++; if (hz.pc_write !== 1'b1) begin bad++; $display("[TB] FAIL mfhi_proceed got=%b exp=1", hz.pc_write); end
    total++; if (stall_cycles !== 32'd4) begin bad++; $display("[TB] FAIL mfhi_count got=%0d exp=4", stall_cycles); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    hz.id_md_op = MD_DIV;
    #1;
    total++; if (hz.md_start !== 1'b1) begin bad++; $display("[TB] FAIL div_start got=%b exp=1", hz.md_start); end
    total++; if (hz.md_is_div !== 1'b1) begin bad++; $display("[TB] FAIL div_is_div got=%b exp=1", hz.md_is_div); end
    @(negedge clk);
    hz.id_md_op = MD_MULT;
    for (int i = 0; i < 32; i++) begin
      #1;
      total++; if ({hz.md_busy, hz.md_start, hz.pc_write} !== 3'b100) begin
        bad++; $display("[TB] FAIL b2b_wait[%0d] got busy/start/pc=%b exp=100", i, {hz.md_busy, hz.md_start, hz.pc_write});
      end
      @(negedge clk);
    end
    #1;
    total++; if ({hz.md_busy, hz.md_start, hz.md_is_div, hz.pc_write} !== 4'b0101) begin
      bad++; $display("[TB] FAIL b2b_issue got busy/start/div/pc=%b exp=0101", {hz.md_busy, hz.md_start, hz.md_is_div, hz.pc_write});
    end
    @(negedge clk);
    clear_inputs();
    #1;
    total++; if (hz.md_busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_mul_busy got=%b exp=1", hz.md_busy); end
    total++; if (stall_cycles !== 32'd32) begin bad++; $display("[TB] FAIL b2b_count got=%0d exp=32", stall_cycles); end
  endtask

  task automatic test_reset_mid_op();
    int busy_n;
    do_reset();
    hz.id_md_op = MD_DIV;
    @(negedge clk);
    hz.id_md_op = MD_NONE; hz.id_reads_hilo = 1'b1;
    for (int i = 0; i < 9; i++) @(negedge clk);
    #1;
    total++; if (hz.md_busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy got=%b exp=1", hz.md_busy); end
    total++; if (stall_cycles !== 32'd9) begin bad++; $display("[TB] FAIL mid_count got=%0d exp=9", stall_cycles); end
    rst = 1'b1;
    #1;
    total++; if (hz.md_busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_busy got=%b exp=0", hz.md_busy); end
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("[TB] FAIL mid_rst_count got=%0d exp=0", stall_cycles); end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    hz.id_md_op = MD_DIV;
    #1;
    total++; if (hz.md_start !== 1'b1) begin bad++; $display("[TB] FAIL post_rst_start got=%b exp=1", hz.md_start); end
    @(negedge clk);
    clear_inputs();
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (hz.md_busy === 1'b1) busy_n++;
      @(negedge clk);
    end
    total++; if (busy_n != 32) begin bad++; $display("[TB] FAIL post_rst_busy_len got=%0d exp=32", busy_n); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    do_reset();
    hz_s.id_ex_mem_read = 1'b1; hz_s.id_ex_write_reg_addr = 5'd5; hz_s.id_rs = 5'd5; hz_s.id_uses_rs = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #1;
      exp_cnt = (k < 3) ? 2'(k) : 2'd3;
      total++; if (stall_cycles_s !== exp_cnt) begin bad++; $display("[TB] FAIL sat_count[%0d] got=%0d exp=%0d", k, stall_cycles_s, exp_cnt); end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_hazard();
    test_mult_mfhi();
    test_back_to_back();
    test_reset_mid_op();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
